// File: rtl/shared_ram_pkg.sv
// Shared definitions for the multicore data-memory subsystem: default sizes
// and the round-robin pointer advance used by the arbiter.
package shared_ram_pkg;

    localparam int CORE_COUNT = 4;
    localparam int DMEM_WIDTH = 12;
    localparam int DMEM_DEPTH = 256;

    // Written as a compare rather than a modulo so no divider is implied.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned num_ports);
        return (ptr >= num_ports - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping around, and moves the pointer just past each winner.
module rr_arbiter
    import shared_ram_pkg::*;
#(
    parameter int N         = 4,
    parameter int PTR_WIDTH = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [PTR_WIDTH-1:0] gntIdx
);

    logic [PTR_WIDTH-1:0] ptr_reg;
    logic [PTR_WIDTH-1:0] cand;
    logic                 found;

    always_comb begin
        gnt    = '0;
        gntIdx = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = PTR_WIDTH'((int'(ptr_reg) + i) % N);
            if (!rst && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                gntIdx    = cand;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (found) begin
            ptr_reg <= PTR_WIDTH'(next_ptr(32'(gntIdx), N));
        end
    end

endmodule

// File: rtl/shared_ram.sv
// Single-port RAM shared by several requesters through a round-robin arbiter;
// reads use a registered address and complete one cycle after the grant.
module shared_ram
    import shared_ram_pkg::*;
#(
    parameter int WIDTH      = DMEM_WIDTH,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_PORTS  = CORE_COUNT,
    parameter int PTR_WIDTH  = $clog2(NUM_PORTS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  req,
    input  logic [NUM_PORTS-1:0]                  wrEn,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr,
    input  logic [NUM_PORTS-1:0][WIDTH-1:0]       dataIn,
    output logic [NUM_PORTS-1:0]                  gnt,
    output logic [NUM_PORTS-1:0]                  rdValid,
    output logic [NUM_PORTS-1:0][WIDTH-1:0]       dataOut
);

    logic [PTR_WIDTH-1:0]  gnt_idx;
    logic                  gnt_any;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_data;
    logic [WIDTH-1:0]      read_word;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [PTR_WIDTH-1:0]  tag_reg;
    logic                  pending_reg;

    logic [WIDTH-1:0]      mem [DEPTH];

    rr_arbiter #(
        .N         (NUM_PORTS),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_arbiter (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .gntIdx (gnt_idx)
    );

    assign gnt_any  = |gnt;
    assign sel_addr = addr[gnt_idx];
    assign sel_data = dataIn[gnt_idx];
    assign wr_fire  = gnt_any & wrEn[gnt_idx];
    assign rd_fire  = gnt_any & ~wrEn[gnt_idx];

    // gnt is forced low during reset, so no write can slip through then.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[sel_addr] <= sel_data;
        end
    end

    assign read_word = mem[addr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg    <= '0;
            tag_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            pending_reg <= rd_fire;
            if (rd_fire) begin
                addr_reg <= sel_addr;
                tag_reg  <= gnt_idx;
            end
        end
    end

    // Each port presents the live read word during its pulse and keeps it afterwards.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [WIDTH-1:0] hold_reg;

            assign rdValid[gi] = pending_reg && (tag_reg == PTR_WIDTH'(gi));
            assign dataOut[gi] = rdValid[gi] ? read_word : hold_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_reg <= '0;
                end else if (rdValid[gi]) begin
                    hold_reg <= read_word;
                end
            end
        end
    endgenerate

endmodule

// File: doc/shared_ram.md
# shared_ram

Single-port synchronous RAM shared by `NUM_PORTS` requesters, such as processor cores, through a round-robin arbiter. It is the parametrised successor of the team's single-requester data/instruction RAM. It keeps the same registered-address read style and one-cycle read latency. It adds per-port request/grant handshakes, per-port read-valid flags and fair arbitration. It sits between the cores and the shared data memory in the multicore top level.

## Interface
Parameters:
- `WIDTH`, 12, data word width in bits
- `DEPTH`, 256, number of words
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width
- `NUM_PORTS`, 4, number of requesters; must be ≥ 2
- `PTR_WIDTH`, `$clog2(NUM_PORTS)`, width of the round-robin pointer

Ports (arrays are packed, index = port number):
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, **asynchronous and active-high**.
- `req` in `[NUM_PORTS-1:0]`: per-port access request.
- `wrEn` in `[NUM_PORTS-1:0]`: per-port write (1) / read (0) select, qualified by `req`.
- `addr` in `[NUM_PORTS-1:0][ADDR_WIDTH-1:0]`: per-port word address.
- `dataIn` in `[NUM_PORTS-1:0][WIDTH-1:0]`: per-port write data.
- `gnt` out `[NUM_PORTS-1:0]`: one-hot grant; combinational, same cycle as `req`.
- `rdValid` out `[NUM_PORTS-1:0]`: one-cycle pulse; read data for that port is on `dataOut`.
- `dataOut` out `[NUM_PORTS-1:0][WIDTH-1:0]`: per-port registered read data.

## Operation
- Each cycle, at most one port is granted: the first port with `req`=1, searching from `ptr` upward and wrapping modulo `NUM_PORTS`.
- `gnt` is all-zero when no `req` is set or while `rst`=1.
- Granted write: `memory[addr[g]] <= dataIn[g]` at the clock edge. `rdValid[g]` stays 0.
- Granted read: the shared address register captures `addr[g]` and a port-tag register captures `g`.
  - Next cycle: `dataOut[g] <= memory[addr_reg]` is registered at the following edge. Alternatively it may be driven directly; either way the data must be valid while `rdValid[g]`=1.
  - `rdValid[g]` pulses for exactly one cycle.
- `dataOut[p]` holds its last read value until port p's next read completes. Other ports' reads never disturb it.
- Pointer update:
  - On any grant to port g: `ptr <= (g+1) mod NUM_PORTS`. Wrap from `NUM_PORTS-1` goes to 0.
  - No grant: `ptr` unchanged.
- Requester rule: hold `req`, `wrEn`, `addr` and `dataIn` stable until the cycle in which `gnt` is seen. Deasserting `req` before grant is legal and the request is dropped. A port may re-request in the cycle after its grant.
- Write-then-read of the same address (any ports, consecutive grants): the read returns the new data.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: `ptr`=0, `rdValid`=0, `dataOut`=0, port tag=0, read-pending=0, `gnt`=0.
- Reset asserted mid-operation:
  - Any pending read is discarded; no `rdValid` after reset is released.
  - No write occurs in a cycle with `rst`=1.
- Write latency: memory is updated at the edge ending the grant cycle.
- Read latency: `rdValid`/`dataOut` are valid 1 cycle after the grant cycle.
- Throughput: one access per cycle total. Back-to-back reads from different ports produce back-to-back `rdValid` pulses on the respective ports.
- Worst-case wait for a continuously requesting port: `NUM_PORTS-1` cycles.
- All outputs except `gnt` are registered.

## Structure
- Shared package `shared_ram_pkg`:
  - `function automatic next_ptr(ptr, NUM_PORTS)`.
  - Localparam defaults for the multicore top (`CORE_COUNT`, `DMEM_WIDTH`, `DMEM_DEPTH`).
- Sub-module `rr_arbiter #(N)` is natural:
  - Inputs: `clk`, `rst`, `req`.
  - Outputs: one-hot `gnt` and `gntIdx`.
  - Owns `ptr`.
- The memory array, address/tag registers and per-port output registers stay in `shared_ram`.

## Test plan
- **Reset**: assert `rst` mid-read (grant read on port 1, `rst` next cycle). Expect `gnt`=0, `rdValid`=0 and `dataOut`=0 on all ports; no pulse after release.
- **Single port**: port 0 writes 12'hABC at address 5, then reads address 5. Expect `rdValid[0]` 1 cycle after the read grant and `dataOut[0]`=12'hABC.
- **Round robin**: all 4 ports request continuously from reset. Expect grants 0,1,2,3,0,… one per cycle, and `ptr` wrapping 3→0.
- **Sparse requests**: `ptr`=2 with only ports 0 and 3 requesting. Expect port 3 granted first, then port 0.
- **Cross-port coherence**: port 2 writes 12'h123 at address 255 (max address). Port 1 reads address 255 in the next cycle and gets 12'h123. `dataOut[0]` must keep its previous value 12'hABC.
- **Hold/drop**: port 3 requests while port 0 is favoured, then drops `req` before its grant. Expect no grant and no write for port 3, and `ptr` unaffected by port 3.
